// File: rtl/game_sequencer.sv
// game_sequencer: round controller for the password-guessing game.
// Each level gets a password sampled from a free-running LFSR and a BCD
// countdown that shrinks per level down to a floor. Guesses arrive on rising
// edges of the debounced enter level; each one is graded into a per-bit LED
// mask, and the FSM advances the level, declares a win, or declares a fail.
// Input protocol: enter is a level. Only its 0->1 transition, seen while in
// PLAY (or IDLE to start), is acted on. Holding it high has no further effect.
module game_sequencer #(
  parameter int          NUM_LEVELS = 9,
  parameter int          BASE_TIME  = 60,
  parameter int          TIME_STEP  = 5,
  parameter int          MIN_TIME   = 10,
  parameter logic [9:0]  SEED       = 10'h2B5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        enter,
  input  logic [9:0]  sw,
  output logic [3:0]  level,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic [9:0]  led,
  output logic [3:0]  attempts,
  output logic [9:0]  password,
  output logic        win,
  output logic        fail,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_CHECK = 3'd3,
    S_WIN   = 3'd4,
    S_FAIL  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  lfsr_q, lfsr_d;
  logic        enter_q;
  logic [3:0]  level_q, level_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [9:0]  led_q, led_d;
  logic [3:0]  att_q, att_d;
  logic [9:0]  pw_q, pw_d;
  logic [9:0]  guess_q, guess_d;

  logic        enter_edge;
  logic        timer_zero;
  int          start_raw;
  logic [6:0]  start_sec;
  logic [3:0]  start_tens;
  logic [3:0]  start_ones;

  assign enter_edge = enter & ~enter_q;
  assign timer_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  // x^10 + x^7 + 1 Fibonacci form; a nonzero seed never reaches zero
  assign lfsr_d     = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  // Level start time, clamped to the floor and split into BCD digits
  always_comb begin
    start_raw = BASE_TIME - (int'(level_q) - 1) * TIME_STEP;
    if (start_raw < MIN_TIME) start_raw = MIN_TIME;
    start_sec  = 7'(start_raw);
    start_tens = 4'(start_sec / 7'd10);
    start_ones = 4'(start_sec % 7'd10);
  end

  // Next-state and datapath updates for the round FSM
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    led_d   = led_q;
    att_d   = att_q;
    pw_d    = pw_q;
    guess_d = guess_q;
    case (state_q)
      S_IDLE: begin
        if (enter_edge) begin
          level_d = 4'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        pw_d    = lfsr_q;
        tens_d  = start_tens;
        ones_d  = start_ones;
        led_d   = '0;
        att_d   = '0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        // A tick and an enter edge in the same cycle both take effect
        if (tick && !timer_zero) begin
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
        if (enter_edge) begin
          guess_d = sw;
          state_d = S_CHECK;
        end else if (timer_zero) begin
          state_d = S_FAIL;
        end
      end
      S_CHECK: begin
        led_d = ~(guess_q ^ pw_q);
        if (guess_q == pw_q) begin
          if (level_q == 4'(NUM_LEVELS)) begin
            state_d = S_WIN;
          end else begin
            level_d = level_q + 4'd1;
            state_d = S_LOAD;
          end
        end else if (!timer_zero) begin
          if (att_q != 4'd15) att_d = att_q + 4'd1;
          state_d = S_PLAY;
        end else begin
          state_d = S_FAIL;
        end
      end
      default: begin
        // WIN and FAIL are terminal: everything holds until reset
      end
    endcase
  end

  // State and datapath registers; reset returns to IDLE immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      enter_q <= 1'b0;
      level_q <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      led_q   <= '0;
      att_q   <= '0;
      pw_q    <= '0;
      guess_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      enter_q <= enter;
      level_q <= level_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      led_q   <= led_d;
      att_q   <= att_d;
      pw_q    <= pw_d;
      guess_q <= guess_d;
    end
  end

  assign level     = level_q;
  assign sec_tens  = tens_q;
  assign sec_ones  = ones_q;
  assign led       = led_q;
  assign attempts  = att_q;
  assign password  = pw_q;
  assign win       = (state_q == S_WIN);
  assign fail      = (state_q == S_FAIL);
  assign dbg_state = state_q;

endmodule
